// File: rtl/ant_rand_pkg.sv
// Shared types and helpers for the bounded random draw block.
package ant_rand_pkg;

  localparam int RAND_W   = 32;
  localparam int SLICE_W  = 8;
  localparam int N_SLICES = RAND_W / SLICE_W;
  localparam int IDX_W    = $clog2(N_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RESP = 2'd2
  } state_e;

  // Smallest all-ones value that covers b-1; b is the effective bound (>= 1).
  function automatic logic [SLICE_W-1:0] bound_to_mask(input logic [SLICE_W-1:0] b);
    logic [SLICE_W-1:0] m;
    m = b - 1'b1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/slice_select.sv
// Priority picker: first masked 8-bit slice of the word that falls below the bound.
module slice_select
  import ant_rand_pkg::*;
(
  input  logic [RAND_W-1:0]  word_i,
  input  logic [SLICE_W-1:0] bound_i,
  input  logic [SLICE_W-1:0] mask_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [SLICE_W-1:0] value_o,
  output logic [SLICE_W-1:0] c0_o
);

  logic [N_SLICES-1:0][SLICE_W-1:0] cand;

  for (genvar g = 0; g < N_SLICES; g++) begin : g_cand
    assign cand[g] = word_i[g*SLICE_W +: SLICE_W] & mask_i;
  end

  assign c0_o = cand[0];

  // Walk from the top slice down so the lowest accepted index wins.
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    value_o = '0;
    for (int i = N_SLICES - 1; i >= 0; i--) begin
      if (cand[i] < bound_i) begin
        hit_o   = 1'b1;
        idx_o   = IDX_W'(i);
        value_o = cand[i];
      end
    end
  end

endmodule

// File: rtl/rand_range_draw.sv
// Serves unbiased random integers in [0, bound-1] from a free-running 32-bit
// random word stream, with a deterministic fallback after MAX_WORDS rejected words.
module rand_range_draw
  import ant_rand_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [RAND_W-1:0]  rnd_in,
  input  logic               rnd_valid,
  input  logic               req_valid,
  input  logic [SLICE_W-1:0] req_bound,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [SLICE_W-1:0] resp_value,
  output logic               resp_fallback,
  input  logic               resp_ready,
  output logic [CNT_W-1:0]   reject_cnt
);

  localparam logic [3:0] LAST_WORD = 4'(MAX_WORDS - 1);

  state_e             state_q, state_d;
  logic [SLICE_W-1:0] bound_q, bound_d;
  logic [3:0]         word_cnt_q, word_cnt_d;
  logic [SLICE_W-1:0] value_q, value_d;
  logic               fb_q, fb_d;
  logic [CNT_W-1:0]   rej_q, rej_d;

  logic [SLICE_W-1:0] mask;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [SLICE_W-1:0] hit_value;
  logic [SLICE_W-1:0] c0;
  logic               draw_fire;
  logic               last_word;
  logic [2:0]         n_rej;
  logic [CNT_W:0]     rej_sum;

  assign mask      = bound_to_mask(bound_q);
  assign draw_fire = (state_q == DRAW) && rnd_valid;
  assign last_word = (word_cnt_q == LAST_WORD);
  assign n_rej     = hit ? {1'b0, hit_idx} : 3'd4;
  assign rej_sum   = {1'b0, rej_q} + (CNT_W+1)'(n_rej);

  slice_select u_sel (
    .word_i  (rnd_in),
    .bound_i (bound_q),
    .mask_i  (mask),
    .hit_o   (hit),
    .idx_o   (hit_idx),
    .value_o (hit_value),
    .c0_o    (c0)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      bound_q    <= 8'd1;
      word_cnt_q <= '0;
      value_q    <= '0;
      fb_q       <= 1'b0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      bound_q    <= bound_d;
      word_cnt_q <= word_cnt_d;
      value_q    <= value_d;
      fb_q       <= fb_d;
      rej_q      <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = DRAW;
      DRAW: if (draw_fire && (hit || last_word)) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bound_d    = bound_q;
    word_cnt_d = word_cnt_q;
    value_d    = value_q;
    fb_d       = fb_q;
    rej_d      = rej_q;
    if (state_q == IDLE && req_valid) begin
      bound_d    = (req_bound == '0) ? 8'd1 : req_bound;
      word_cnt_d = '0;
    end
    if (draw_fire) begin
      rej_d = rej_sum[CNT_W] ? '1 : rej_sum[CNT_W-1:0];
      if (hit) begin
        value_d = hit_value;
        fb_d    = 1'b0;
      end else begin
        word_cnt_d = word_cnt_q + 4'd1;
        // c0 was rejected and mask < 2B, so c0 - B is already in range.
        if (last_word) begin
          value_d = c0 - bound_q;
          fb_d    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    resp_valid    = (state_q == RESP);
    resp_value    = value_q;
    resp_fallback = fb_q;
    reject_cnt    = rej_q;
  end

endmodule
